cram_dump_scanner: RTL and testbench
====================================

CRAM_DUMP_SCANNER -- requirements
Module: cram_dump_scanner

Interface
REQ-001 Parameter p_data_width, default 16: RAM word width; SHALL be a multiple of 8.
REQ-002 Parameter p_address_width, default 10: RAM address width.
REQ-003 i_w_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_w_reset  input  1  asynchronous, active-high reset.
REQ-005 i_w_start  input  1  single-cycle dump request.
REQ-006 i_w_start_address  input  p_address_width  first word address, sampled when a start is accepted.
REQ-007 i_w_end_address  input  p_address_width  last word address (inclusive), sampled when a start is accepted.
REQ-008 i_w_abort  input  1  stop the dump at the next byte boundary.
REQ-009 o_w_disp_address  output  p_address_width  read address to the RAM display port.
REQ-010 i_w_disp_data  input  p_data_width  RAM display-port data; valid one clock after o_w_disp_address.
REQ-011 o_r_tx_data  output  8  byte to the downstream serial transmitter.
REQ-012 o_r_tx_valid  output  1  o_r_tx_data is valid.
REQ-013 i_w_tx_ready  input  1  downstream accepts the byte this cycle.
REQ-014 o_r_busy  output  1  dump in progress.
REQ-015 o_r_done  output  1  one-cycle pulse when a dump ends, whether completed or aborted.

Function
REQ-016 FSM states: IDLE, FETCH, CAPTURE, SEND, DONE.
REQ-017 IDLE + i_w_start=1 -> latch start/end addresses, load the address register with start, go to FETCH.
- i_w_start is ignored in every state except IDLE.
REQ-018 o_w_disp_address SHALL always equal the address register.
REQ-019 FETCH: lasts exactly one cycle, then go to CAPTURE.
REQ-020 CAPTURE: latch i_w_disp_data into the shift register, load the byte counter with p_data_width/8, go to SEND.
REQ-021 SEND: o_r_tx_valid=1 with o_r_tx_data = most-significant unsent byte; bytes go out MSB first.
REQ-022 Handshake: a byte transfers when o_r_tx_valid && i_w_tx_ready are both high.
- Until transfer, o_r_tx_valid and o_r_tx_data SHALL hold stable.
- Any number of ready stall cycles SHALL be tolerated.
REQ-023 After the last byte of a word transfers:
- if address == end address, go to DONE;
- otherwise increment the address modulo 2^p_address_width and go to FETCH.
REQ-024 Wrap-around: end < start dumps start..max, then 0..end; start == end dumps exactly one word.
REQ-025 Abort: i_w_abort is sampled in FETCH, CAPTURE and SEND.
- In FETCH or CAPTURE, go to DONE immediately.
- In SEND, the byte currently offered completes its handshake, then go to DONE; no further bytes are offered.
- i_w_abort in IDLE or DONE is ignored.
REQ-026 DONE: o_r_done=1 for exactly one cycle, then go to IDLE.
REQ-027 o_r_busy=1 in every state except IDLE.
REQ-028 Latency: start sampled at edge k -> FETCH at k+1 -> CAPTURE at k+2 -> first o_r_tx_valid=1 at k+3.
REQ-029 Per-word overhead outside SEND is 2 cycles (FETCH, CAPTURE).
REQ-030 All outputs are registered, except o_w_disp_address, which is a direct copy of the address register.

Reset
REQ-031 Reset asserted -> immediately, regardless of clock:
- state IDLE;
- o_r_tx_valid=0, o_r_tx_data=0, o_r_busy=0, o_r_done=0;
- address register=0, shift register=0, byte counter=0.
REQ-032 Reset mid-dump abandons the dump with no o_r_done pulse; the first clock edge after deassertion SHALL sample only in IDLE.

Structure
REQ-033 Package cram_dump_pkg SHALL hold:
- the FSM state enumeration;
- the byte-width constant (8);
- the bytes-per-word derivation.
REQ-034 One sub-module, word_serializer, SHALL contain the shift register, byte counter and valid/ready handshake; cram_dump_scanner contains the FSM and address logic.
REQ-035 The block SHALL connect directly to the RAM display port in the same i_w_clk domain, with one-cycle read latency.

Verification
REQ-036 Basic dump: RAM[0x010]=0xA1B2, RAM[0x011]=0xC3D4; start=0x010, end=0x011, ready always 1.
- Required: bytes A1,B2,C3,D4 in order; first valid 3 cycles after start; one o_r_done pulse.
REQ-037 Backpressure: same setup as REQ-036, ready low for 5 cycles while byte B2 is offered.
- Required: B2 held stable throughout; no byte lost or duplicated.
REQ-038 Wrap: start=0x3FF, end=0x000, RAM[0x3FF]=0x1234, RAM[0x000]=0x5678.
- Required: bytes 12,34,56,78; o_w_disp_address sequence 0x3FF then 0x000.
REQ-039 Abort: abort pulsed while byte 0x12 of a 4-word dump waits with ready=0; ready raised 2 cycles later.
- Required: 0x12 transfers, no further bytes, o_r_done pulses once, then idle.
REQ-040 Start during busy is ignored: second start with different addresses mid-dump.
- Required: original range completes unchanged.
REQ-041 Async reset mid-SEND.
- Required: o_r_tx_valid=0 and o_r_busy=0 without a clock edge; no o_r_done; a new start then dumps correctly.

Source files
------------

// File: rtl/cram_dump_pkg.sv
// cram_dump_pkg: shared FSM states and byte/word sizing for the CRAM dump scanner.
// Revision 1.0
`default_nettype none

package cram_dump_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SEND    = 3'd3,
    ST_DONE    = 3'd4
  } dump_state_t;

  function automatic int bytes_per_word(input int data_width);
    return data_width / BYTE_WIDTH;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cram_dump_scanner_word_serializer.sv
// word_serializer: splits one RAM word into bytes, MSB first, over a valid/ready link.
// Revision 1.0
`default_nettype none

module word_serializer
  import cram_dump_pkg::*;
#(
  parameter int p_data_width = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [p_data_width-1:0] load_data,
  input  logic                    flush,
  input  logic                    tx_ready,
  output logic [BYTE_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  output logic                    xfer,
  output logic                    last_byte
);

  localparam int BPW = bytes_per_word(p_data_width);
  localparam int CW  = $clog2(BPW + 1);

  logic [p_data_width-1:0] shift_reg;
  logic [CW-1:0]           byte_count;

  assign xfer      = tx_valid && tx_ready;
  assign last_byte = (byte_count == CW'(1));

  // tx_data always holds the byte on offer; shift_reg holds the bytes still to come.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg  <= '0;
      byte_count <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
    end else if (load) begin
      tx_data    <= load_data[p_data_width-1 -: BYTE_WIDTH];
      shift_reg  <= load_data << BYTE_WIDTH;
      byte_count <= CW'(BPW);
      tx_valid   <= 1'b1;
    end else if (xfer) begin
      if (last_byte || flush) begin
        tx_valid   <= 1'b0;
        byte_count <= '0;
      end else begin
        tx_data    <= shift_reg[p_data_width-1 -: BYTE_WIDTH];
        shift_reg  <= shift_reg << BYTE_WIDTH;
        byte_count <= byte_count - CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cram_dump_scanner.sv
// cram_dump_scanner: walks a RAM address range and streams each word out bytewise.
// Revision 1.0
`default_nettype none

module cram_dump_scanner
  import cram_dump_pkg::*;
#(
  parameter int p_data_width    = 16,
  parameter int p_address_width = 10
) (
  input  logic                       i_w_clk,
  input  logic                       i_w_reset,
  input  logic                       i_w_start,
  input  logic [p_address_width-1:0] i_w_start_address,
  input  logic [p_address_width-1:0] i_w_end_address,
  input  logic                       i_w_abort,
  output logic [p_address_width-1:0] o_w_disp_address,
  input  logic [p_data_width-1:0]    i_w_disp_data,
  output logic [BYTE_WIDTH-1:0]      o_r_tx_data,
  output logic                       o_r_tx_valid,
  input  logic                       i_w_tx_ready,
  output logic                       o_r_busy,
  output logic                       o_r_done
);

  dump_state_t                state;
  dump_state_t                next_state;
  logic [p_address_width-1:0] addr_reg;
  logic [p_address_width-1:0] end_reg;
  logic                       abort_pending;
  logic                       stop_req;
  logic                       load;
  logic                       xfer;
  logic                       last_byte;

  assign o_w_disp_address = addr_reg;
  // An abort seen during SEND lets the offered byte finish, then ends the dump.
  assign stop_req = abort_pending || ((state == ST_SEND) && i_w_abort);

  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_w_start) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        next_state = i_w_abort ? ST_DONE : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (i_w_abort) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_SEND;
          load       = 1'b1;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (stop_req || (last_byte && (addr_reg == end_reg))) next_state = ST_DONE;
          else if (last_byte) next_state = ST_FETCH;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state         <= ST_IDLE;
      addr_reg      <= '0;
      end_reg       <= '0;
      abort_pending <= 1'b0;
      o_r_busy      <= 1'b0;
      o_r_done      <= 1'b0;
    end else begin
      state         <= next_state;
      o_r_busy      <= (next_state != ST_IDLE);
      o_r_done      <= (next_state == ST_DONE);
      abort_pending <= (state == ST_SEND) && (next_state == ST_SEND) && stop_req;
      if ((state == ST_IDLE) && i_w_start) begin
        addr_reg <= i_w_start_address;
        end_reg  <= i_w_end_address;
      end else if ((state == ST_SEND) && (next_state == ST_FETCH)) begin
        addr_reg <= addr_reg + p_address_width'(1);
      end
    end
  end

  word_serializer #(
    .p_data_width(p_data_width)
  ) u_word_serializer (
    .clk       (i_w_clk),
    .reset     (i_w_reset),
    .load      (load),
    .load_data (i_w_disp_data),
    .flush     (stop_req),
    .tx_ready  (i_w_tx_ready),
    .tx_data   (o_r_tx_data),
    .tx_valid  (o_r_tx_valid),
    .xfer      (xfer),
    .last_byte (last_byte)
  );

endmodule

`default_nettype wire

// File: tb/tb_cram_dump_scanner.sv
// tb_cram_dump_scanner: scoreboard bench with a RAM model and a byte-stream reference model.
// Revision 1.0
`default_nettype none

module tb_cram_dump_scanner;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int BPW   = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          tx_ready = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [DEPTH];

  int            total = 0;
  int            bad = 0;
  int            done_count = 0;
  logic [7:0]    exp_q[$];
  logic [AW-1:0] addr_log[$];
  int            ready_mode = 0;
  logic          manual_ready = 1'b0;

  always #5 clk = ~clk;

  cram_dump_scanner #(
    .p_data_width   (DW),
    .p_address_width(AW)
  ) dut (
    .i_w_clk          (clk),
    .i_w_reset        (rst),
    .i_w_start        (start),
    .i_w_start_address(start_addr),
    .i_w_end_address  (end_addr),
    .i_w_abort        (abort),
    .o_w_disp_address (disp_addr),
    .i_w_disp_data    (disp_data),
    .o_r_tx_data      (tx_data),
    .o_r_tx_valid     (tx_valid),
    .i_w_tx_ready     (tx_ready),
    .o_r_busy         (busy),
    .o_r_done         (done)
  );

  // Synchronous RAM display port, one-cycle read latency
  always @(posedge clk) disp_data <= mem[disp_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: actual=0x%0h required=none", name, act);
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = follow manual_ready
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = manual_ready;
      endcase
    end
  end

  // Monitor: pops expected bytes on each handshake, checks hold-while-stalled, counts done pulses
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(tx_valid), 32'd1);
          check("hold_data", 32'(tx_data), 32'(prev_data));
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) fail_now("extra_byte", 32'(tx_data));
          else begin
            e = exp_q.pop_front();
            check("byte", 32'(tx_data), 32'(e));
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (done) done_count++;
        if (busy && (addr_log.size() == 0 || addr_log[$] != disp_addr)) addr_log.push_back(disp_addr);
      end
    end
  end

  // Reference model: every word from s through e inclusive, wrapping past the top, MSB byte first
  task automatic model_dump(input int s, input int e);
    int a;
    logic [DW-1:0] w;
    a = s;
    for (int n = 0; n < DEPTH; n++) begin
      w = mem[a];
      for (int b = BPW - 1; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
      if (a == e) break;
      a = (a + 1) % DEPTH;
    end
  endtask

  task automatic issue_start(input int s, input int e);
    start      = 1'b1;
    start_addr = AW'(s);
    end_addr   = AW'(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!tx_valid && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!tx_valid) fail_now({name, "_valid_timeout"}, 32'(n));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) fail_now({name, "_idle_timeout"}, 32'(n));
  endtask

  task automatic end_check(input string name, input int exp_done);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_done_pulses"}, 32'(done_count), 32'(exp_done));
    exp_q.delete();
    addr_log.delete();
    done_count = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s;
    int len;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);

    #1 rst = 1'b1;
    #2;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_addr", 32'(disp_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic dump with latency check
    ready_mode = 0;
    mem[10'h010] = 16'hA1B2;
    mem[10'h011] = 16'hC3D4;
    model_dump(10'h010, 10'h011);
    issue_start(10'h010, 10'h011);
    n = 1;
    while (!tx_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("basic_latency", 32'(n), 32'd3);
    check("basic_first", 32'(tx_data), 32'hA1);
    wait_idle("basic", 100);
    end_check("basic", 1);

    // Backpressure on the second byte
    ready_mode   = 2;
    manual_ready = 1'b0;
    model_dump(10'h010, 10'h011);
    issue_start(10'h010, 10'h011);
    wait_valid("bp", 20);
    manual_ready = 1'b1;
    @(posedge clk);
    #1;
    manual_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("bp_stalled_byte", 32'(tx_data), 32'hB2);
    manual_ready = 1'b1;
    wait_idle("bp", 100);
    end_check("bp", 1);
    ready_mode = 0;

    // Wrap-around from the top address
    mem[10'h3FF] = 16'h1234;
    mem[10'h000] = 16'h5678;
    model_dump(10'h3FF, 10'h000);
    issue_start(10'h3FF, 10'h000);
    wait_idle("wrap", 100);
    check("wrap_addr_count", 32'(addr_log.size()), 32'd2);
    if (addr_log.size() >= 2) begin
      check("wrap_addr0", 32'(addr_log[0]), 32'h3FF);
      check("wrap_addr1", 32'(addr_log[1]), 32'h000);
    end
    end_check("wrap", 1);

    // Abort while the first byte waits
    mem[10'h100] = 16'h12AB;
    ready_mode   = 2;
    manual_ready = 1'b0;
    exp_q.push_back(8'h12);
    issue_start(10'h100, 10'h103);
    wait_valid("abort", 20);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(posedge clk);
    #1;
    manual_ready = 1'b1;
    wait_idle("abort", 100);
    end_check("abort", 1);
    check("abort_valid_low", 32'(tx_valid), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    // Start during a dump is ignored
    ready_mode = 1;
    model_dump(10'h200, 10'h203);
    issue_start(10'h200, 10'h203);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("busy_mid_dump", 32'(busy), 32'd1);
    issue_start(10'h050, 10'h060);
    wait_idle("restart", 500);
    end_check("restart", 1);

    // Asynchronous reset while a byte is offered
    ready_mode   = 2;
    manual_ready = 1'b0;
    issue_start(10'h300, 10'h301);
    wait_valid("areset", 20);
    #2 rst = 1'b1;
    #1;
    check("areset_valid", 32'(tx_valid), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("areset_no_done", 32'(done_count), 32'd0);
    check("areset_stays_idle", 32'(busy), 32'd0);
    ready_mode = 0;
    model_dump(10'h300, 10'h301);
    issue_start(10'h300, 10'h301);
    wait_idle("areset_redump", 100);
    end_check("areset_redump", 1);

    // Randomized ranges with random backpressure
    ready_mode = 1;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      s   = (t == 0) ? DEPTH - 2 : int'($urandom_range(0, DEPTH - 1));
      len = int'($urandom_range(1, 5));
      model_dump(s, (s + len - 1) % DEPTH);
      issue_start(s, (s + len - 1) % DEPTH);
      wait_idle("rand", 500);
      end_check("rand", 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
